// File: rtl/rcu_clk_mon_if.sv
// Control/status bundle between the clock monitor and its register-side owner.
// The master drives configuration and enable; the slave is the monitor itself.
interface rcu_clk_mon_if #(
  parameter int WIN_WIDTH = 16,
  parameter int CNT_WIDTH = 16
);
  logic                 en_i;
  logic                 clr_i;
  logic [WIN_WIDTH-1:0] win_i;
  logic [CNT_WIDTH-1:0] lo_thr_i;
  logic [CNT_WIDTH-1:0] hi_thr_i;
  logic [CNT_WIDTH-1:0] cnt_o;
  logic                 valid_o;
  logic                 busy_o;
  logic                 lock_o;
  logic                 err_o;
  logic                 irq_o;

  modport master (
    output en_i, clr_i, win_i, lo_thr_i, hi_thr_i,
    input  cnt_o, valid_o, busy_o, lock_o, err_o, irq_o
  );

  modport slave (
    input  en_i, clr_i, win_i, lo_thr_i, hi_thr_i,
    output cnt_o, valid_o, busy_o, lock_o, err_o, irq_o
  );
endinterface

// File: rtl/rcu_clk_mon.sv
// Frequency monitor for one RCU output clock: counts synchronised rising edges per window.
// Optional macro RCU_CLK_MON_IRQ_EN adds a sticky irq_o on lock loss / error set.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | monitor disabled, waiting for en_i
//   ST_SETTLE | SYNC_STAGES+1 cycles flushing stale synchroniser contents
//   ST_MEAS   | counting rises over a max(win_i,2)-cycle window
//   ST_CHECK  | publish count, range test, update streak/lock/err
module rcu_clk_mon #(
  parameter int WIN_WIDTH   = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         mon_clk_i,
  rcu_clk_mon_if.slave bus
);

  localparam int SET_W = $clog2(SYNC_STAGES + 1);
  localparam int STK_W = $clog2(LOCK_CNT + 1);

  localparam logic [SET_W-1:0]     SET_LOAD = SET_W'(SYNC_STAGES);
  localparam logic [STK_W-1:0]     STK_MAX  = STK_W'(LOCK_CNT);
  localparam logic [WIN_WIDTH-1:0] WIN_MIN  = WIN_WIDTH'(2);
  localparam logic [WIN_WIDTH-1:0] WIN_ONE  = WIN_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_MEAS   = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 meas_load;
  logic                 abort;
  logic                 chk_fire;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                 edge_q;
  logic                 rise;

  logic [SET_W-1:0]     settle_q;
  logic [WIN_WIDTH-1:0] win_cnt_q;
  logic [WIN_WIDTH-1:0] win_load;
  logic [CNT_WIDTH-1:0] count_q;

  logic                 in_range;
  logic [STK_W-1:0]     streak_q;
  logic [STK_W-1:0]     streak_inc;
  logic                 lock_q;
  logic                 err_q;
  logic                 valid_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  // Synchroniser runs in every state so SETTLE only has to wait it out.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    meas_load = 1'b0;
    abort     = 1'b0;
    chk_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.en_i) begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!bus.en_i) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else if (settle_q == '0) begin
          state_d   = ST_MEAS;
          meas_load = 1'b1;
        end
      end
      ST_MEAS: begin
        if (!bus.en_i) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end else if (win_cnt_q == WIN_ONE) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        chk_fire = 1'b1;
        if (bus.en_i) begin
          state_d   = ST_MEAS;
          meas_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign win_load = (bus.win_i < WIN_MIN) ? WIN_MIN : bus.win_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      settle_q <= '0;
    end else if (state_q == ST_IDLE && bus.en_i) begin
      settle_q <= SET_LOAD;
    end else if (state_q == ST_SETTLE && settle_q != '0) begin
      settle_q <= settle_q - SET_W'(1);
    end
  end

  // Window terminates when the down-counter reads 1, so the final cycle's rise still counts.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      win_cnt_q <= '0;
      count_q   <= '0;
    end else if (meas_load) begin
      win_cnt_q <= win_load;
      count_q   <= '0;
    end else if (state_q == ST_MEAS) begin
      win_cnt_q <= win_cnt_q - WIN_ONE;
      if (rise && count_q != '1) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign in_range   = (count_q >= bus.lo_thr_i) && (count_q <= bus.hi_thr_i);
  assign streak_inc = (streak_q == STK_MAX) ? streak_q : streak_q + STK_W'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      streak_q <= '0;
      lock_q   <= 1'b0;
    end else begin
      valid_q <= chk_fire;
      if (chk_fire) begin
        cnt_q <= count_q;
        if (in_range) begin
          streak_q <= streak_inc;
          lock_q   <= (streak_inc == STK_MAX);
        end else begin
          streak_q <= '0;
          lock_q   <= 1'b0;
        end
      end else if (abort) begin
        streak_q <= '0;
        lock_q   <= 1'b0;
      end
    end
  end

  // A new out-of-range result outranks a coincident clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else if (chk_fire && !in_range) begin
      err_q <= 1'b1;
    end else if (bus.clr_i) begin
      err_q <= 1'b0;
    end
  end

`ifdef RCU_CLK_MON_IRQ_EN
  logic irq_evt_q;
  logic irq_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      irq_evt_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      irq_evt_q <= chk_fire && !in_range && (lock_q || !err_q);
      if (irq_evt_q) begin
        irq_q <= 1'b1;
      end else if (bus.clr_i) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign bus.irq_o = irq_q;
`else
  assign bus.irq_o = 1'b0;
`endif

  assign bus.cnt_o   = cnt_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = (state_q != ST_IDLE);
  assign bus.lock_o  = lock_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_rcu_clk_mon.sv
// Scoreboard bench for rcu_clk_mon: expected window results are queued as stimulus is
// applied and retired on each valid_o; a CNT_WIDTH=4 instance covers counter saturation.
module tb_rcu_clk_mon;

`ifdef RCU_CLK_MON_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  typedef struct {
    logic [15:0] cnt;
    bit          use_cnt;
    logic        lock;
    logic        err;
  } exp_t;

  logic clk_i     = 1'b0;
  logic rst_n_i   = 1'b0;
  logic mon_clk_i = 1'b0;
  int   div       = 10;
  int   phase     = 0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sbq[$];

  rcu_clk_mon_if #(.WIN_WIDTH(16), .CNT_WIDTH(16)) bus ();
  rcu_clk_mon_if #(.WIN_WIDTH(16), .CNT_WIDTH(4))  bus4 ();

  rcu_clk_mon #(.WIN_WIDTH(16), .CNT_WIDTH(16), .SYNC_STAGES(2), .LOCK_CNT(4)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .mon_clk_i (mon_clk_i),
    .bus       (bus)
  );

  rcu_clk_mon #(.WIN_WIDTH(16), .CNT_WIDTH(4), .SYNC_STAGES(2), .LOCK_CNT(4)) dut4 (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .mon_clk_i (mon_clk_i),
    .bus       (bus4)
  );

  initial forever #5 clk_i = ~clk_i;

  // Monitored clock = clk_i/div, stepped away from the active edge.
  initial forever begin
    @(posedge clk_i);
    #2;
    phase     = (phase + 1 >= div) ? 0 : phase + 1;
    mon_clk_i = (phase < div / 2);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] c, input bit uc, input logic l, input logic e);
    exp_t x;
    x.cnt     = c;
    x.use_cnt = uc;
    x.lock    = l;
    x.err     = e;
    sbq.push_back(x);
  endtask

  task automatic get_obs(input int sel, output logic v, output logic [15:0] c,
                         output logic l, output logic e);
    if (sel == 0) begin
      v = bus.valid_o;
      c = bus.cnt_o;
      l = bus.lock_o;
      e = bus.err_o;
    end else begin
      v = bus4.valid_o;
      c = {12'd0, bus4.cnt_o};
      l = bus4.lock_o;
      e = bus4.err_o;
    end
  endtask

  task automatic pop_check(input int sel, input string tag);
    logic v, l, e;
    logic [15:0] c;
    exp_t x;
    get_obs(sel, v, c, l, e);
    check({tag, "_valid"}, v, 1);
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, sbq.size(), 1);
    end else begin
      x = sbq.pop_front();
      if (x.use_cnt) check({tag, "_cnt"}, c, x.cnt);
      check({tag, "_lock"}, l, x.lock);
      check({tag, "_err"}, e, x.err);
    end
  endtask

  // Counts edges until valid_o is seen; cyc=1 means valid right after the next edge.
  task automatic wait_valid(input int sel, input int budget, input string tag, output int cyc);
    logic v, l, e;
    logic [15:0] c;
    cyc = 0;
    v   = 1'b0;
    while (!v && cyc < budget) begin
      @(posedge clk_i);
      #1;
      cyc++;
      get_obs(sel, v, c, l, e);
    end
    if (!v) check({tag, "_timeout"}, v, 1);
    else    pop_check(sel, tag);
  endtask

  initial begin
    int  cyc;
    logic saw_valid;

    bus.en_i = 1'b0;  bus.clr_i = 1'b0;  bus.win_i = 16'd100;
    bus.lo_thr_i = 16'd9;  bus.hi_thr_i = 16'd11;
    bus4.en_i = 1'b0; bus4.clr_i = 1'b0; bus4.win_i = 16'd100;
    bus4.lo_thr_i = 4'd0;  bus4.hi_thr_i = 4'd14;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cnt",   bus.cnt_o,   0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_busy",  bus.busy_o,  0);
    check("rst_lock",  bus.lock_o,  0);
    check("rst_err",   bus.err_o,   0);
    check("rst_irq",   bus.irq_o,   0);
    check("rst4_cnt",  bus4.cnt_o,  0);
    rst_n_i = 1'b1;

    // clk/10 over 100 cycles: 10 edges, lock after four windows
    div = 10;
    @(posedge clk_i); #1;
    bus.en_i = 1'b1;
    @(posedge clk_i);
    push_exp(16'd10, 1, 0, 0);
    wait_valid(0, 300, "first", cyc);
    check("first_lat", cyc, 104);
    check("busy_run", bus.busy_o, 1);
    push_exp(16'd10, 1, 0, 0);
    push_exp(16'd10, 1, 0, 0);
    push_exp(16'd10, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      wait_valid(0, 150, "lockup", cyc);
      check("win_period", cyc, 101);
    end

    // Slow down to clk/20: first window is a mix, the next one is exactly 5
    div = 20;
    push_exp(16'd0, 0, 0, 1);
    wait_valid(0, 150, "slow_mix", cyc);
    check("irq_same_cyc", bus.irq_o, 0);
    @(posedge clk_i); #1;
    check("irq_next_cyc", bus.irq_o, IRQ_EXP);
    push_exp(16'd5, 1, 0, 1);
    wait_valid(0, 150, "slow", cyc);
    bus.clr_i = 1'b1;
    @(posedge clk_i); #1;
    bus.clr_i = 1'b0;
    check("clr_err", bus.err_o, 0);
    check("clr_irq", bus.irq_o, 0);
    bus.en_i = 1'b0;
    @(posedge clk_i); #1;
    check("dis_busy", bus.busy_o, 0);

    // win_i=0 then 1 with clk/2: 2-cycle windows holding one edge each
    div = 2;
    bus.win_i = 16'd0; bus.lo_thr_i = 16'd1; bus.hi_thr_i = 16'd1;
    bus.en_i = 1'b1;
    @(posedge clk_i);
    push_exp(16'd1, 1, 0, 0);
    wait_valid(0, 20, "w0_first", cyc);
    check("w0_lat", cyc, 6);
    push_exp(16'd1, 1, 0, 0);
    push_exp(16'd1, 1, 0, 0);
    push_exp(16'd1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      wait_valid(0, 10, "w0", cyc);
      check("w0_period", cyc, 3);
    end
    bus.win_i = 16'd1;
    push_exp(16'd1, 1, 1, 0);
    push_exp(16'd1, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      wait_valid(0, 10, "w1", cyc);
      check("w1_period", cyc, 3);
    end
    bus.en_i = 1'b0;
    @(posedge clk_i); #1;
    check("w1_dis_busy", bus.busy_o, 0);
    check("w1_dis_lock", bus.lock_o, 0);

    // Abort mid-window: no valid, cnt_o retained, then full restart
    div = 10;
    bus.win_i = 16'd100; bus.lo_thr_i = 16'd9; bus.hi_thr_i = 16'd11;
    bus.en_i = 1'b1;
    @(posedge clk_i);
    saw_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_i); #1;
      saw_valid = saw_valid | bus.valid_o;
    end
    bus.en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      saw_valid = saw_valid | bus.valid_o;
    end
    check("abort_busy",  bus.busy_o, 0);
    check("abort_valid", saw_valid,  0);
    check("abort_cnt",   bus.cnt_o,  1);
    check("abort_lock",  bus.lock_o, 0);
    bus.en_i = 1'b1;
    @(posedge clk_i);
    push_exp(16'd10, 1, 0, 0);
    wait_valid(0, 300, "reen", cyc);
    check("reen_lat", cyc, 104);

    // Inverted thresholds: every window errors; clr in CHECK loses to the set
    bus.lo_thr_i = 16'd12; bus.hi_thr_i = 16'd8;
    push_exp(16'd10, 1, 0, 1);
    wait_valid(0, 150, "inv", cyc);
    repeat (100) @(posedge clk_i);
    #1;
    bus.clr_i = 1'b1;
    push_exp(16'd10, 1, 0, 1);
    @(posedge clk_i); #1;
    bus.clr_i = 1'b0;
    pop_check(0, "inv_clr_chk");
    bus.clr_i = 1'b1;
    @(posedge clk_i); #1;
    bus.clr_i = 1'b0;
    check("inv_clr_mid", bus.err_o, 0);
    push_exp(16'd10, 1, 0, 1);
    wait_valid(0, 150, "inv_again", cyc);
    bus.en_i = 1'b0;

    // 4-bit counter, clk/4 over 100 cycles: 25 edges saturate at 15
    div = 4;
    bus4.en_i = 1'b1;
    @(posedge clk_i);
    push_exp(16'd15, 1, 0, 1);
    wait_valid(1, 300, "sat", cyc);
    check("sat_lat", cyc, 104);
    push_exp(16'd15, 1, 0, 1);
    wait_valid(1, 150, "sat2", cyc);
    bus4.en_i = 1'b0;
    repeat (3) @(posedge clk_i);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
